// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/execute sequencer for register-register ALU instructions.
// Moore FSM; strobes decode from the state register and the IR read back from the datapath.
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        MemDone,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        LOin,
    output logic        HIin,
    output logic [4:0]  ALUop,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic        Run
);
    typedef enum logic [3:0] {S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT} state_t;
    localparam logic [4:0] HALT_OP = 5'b11011;
    state_t state_q, state_d, bound_state;
    logic lock_q, lock_d;
    logic [4:0] opcode;
    logic is_md, is_alu;
    logic unused_ir;
    assign opcode = IR[31:27];
    assign is_md = opcode == 5'b01111 || opcode == 5'b10000;
    assign is_alu = is_md || (opcode >= 5'b00011 && opcode <= 5'b00110);
    assign bound_state = Stop ? S_HALT : S_T0;
    assign unused_ir = ^IR[14:0];
    // A halt opcode locks HALT so that only Clear can restart the machine.
    always_comb begin
        state_d = state_q;
        lock_d = lock_q | (state_q == S_T3 && opcode == HALT_OP);
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    state_d = MemDone ? S_T2 : S_T1;
            S_T2:    state_d = S_T3;
            S_T3:    state_d = is_alu ? S_T4 : (opcode == HALT_OP) ? S_HALT : bound_state;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = is_md ? S_T6 : bound_state;
            S_T6:    state_d = bound_state;
            S_HALT:  state_d = (lock_q || Stop) ? S_HALT : S_T0;
            default: state_d = S_RESET;
        endcase
    end
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_RESET;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end
    always_comb begin
        {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin} = '0;
        {ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin} = '0;
        ALUop = '0;
        Rin = '0;
        Rout = '0;
        Run = state_q != S_RESET && state_q != S_HALT;
        case (state_q)
            S_T0: {PCout, MARin, IncPC, PCin} = 4'hf;
            S_T1: {Read, MDRin} = 2'b11;
            S_T2: {MDRout, IRin} = 2'b11;
            S_T3: begin
                Yin = is_alu;
                Rout = is_alu ? 16'd1 << IR[22:19] : 16'd0;
            end
            S_T4: begin
                Rout = 16'd1 << IR[18:15];
                ALUop = opcode;
                ZLowIn = 1'b1;
                ZHighIn = is_md;
            end
            S_T5: begin
                Zlowout = 1'b1;
                LOin = is_md;
                Rin = is_md ? 16'd0 : 16'd1 << IR[26:23];
            end
            S_T6: {ZHighout, HIin} = 2'b11;
            default: ;
        endcase
    end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the DataPath through instruction fetch and execute for register-register ALU instructions, producing the same strobes the datapath benches apply by hand (PCout, MARin, Read, MDRin, MDRout, IRin, Yin, Z-in/out, register in/out). It sits beside DataPath, reads the IR contents back from it, waits on a memory-done handshake, and sequences T0–T6 per instruction until halted.

## Interface
- No parameters; the register file is fixed at 16 registers and instructions are 32 bits.
- Clock  in  1  rising-edge system clock.
- Clear  in  1  asynchronous, active-low reset.
- IR  in  32  datapath IR contents: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
- MemDone  in  1  memory read complete; MDR data is valid during that cycle.
- Stop  in  1  halt request, sampled at instruction boundaries.
- PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes.
- ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin  out  1 each  Z/HI/LO strobes.
- ALUop  out  5  ALU operation code; valid only in T4.
- Rin  out  16  one-hot register load enable.
- Rout  out  16  one-hot register bus drive.
- Run  out  1  high while executing; low in RESET and HALT.

## Operation
- Moore FSM; outputs decode from the state register and IR. Every output is 0 unless listed for the current state.
- States: RESET, T0, T1, T2, T3, T4, T5, T6, HALT.
- RESET: all outputs 0, Run=0. The first rising edge after Clear rises moves to T0.
- T0: PCout, MARin, IncPC, PCin. Goes to T1.
- T1: Read, MDRin. Stays in T1 while MemDone=0; goes to T2 on the edge where MemDone=1.
- T2: MDRout, IRin. Goes to T3. The IR is valid from T3 onward.
- T3 decodes the opcode:
  - ALU ops: add 00011, sub 00100, and 00101, or 00110, mul 01111, div 10000.
  - For ALU ops, assert Rout[Rb] and Yin, then go to T4.
  - nop 11010: no strobes; go to the boundary.
  - halt 11011: go to HALT.
  - Any other opcode is treated as nop.
- T4: Rout[Rc], ALUop=opcode, ZLowIn. ZHighIn is also asserted for mul/div. Goes to T5.
- T5:
  - add/sub/and/or: Zlowout and Rin[Ra], then the boundary.
  - mul/div: Zlowout and LOin (Ra ignored), then T6.
- T6: ZHighout, HIin. Then the boundary.
- Boundary (any transition into T0): if Stop=1, go to HALT instead.
- HALT: Run=0, all strobes 0. Returns to T0 on the first edge with Stop=0, except when entered by the halt opcode; that case exits only through reset.
- Rin and Rout are never more than one-hot. Register 0 is writable.
- Clear low in any state, including mid-wait in T1: all outputs go to 0 immediately and the state becomes RESET. The fetch in progress is abandoned.

## Timing
- Each state lasts one cycle, except T1, which lasts 1 + (cycles MemDone stays low).
- Cycles from T0 entry to the next T0 entry, with MemDone=1 on the first T1 cycle:
  - add/sub/and/or: 6.
  - mul/div: 7.
  - nop or illegal opcode: 4.
- MemDone arriving in the same cycle Read first asserts is legal; T1 then lasts 1 cycle.
- MemDone outside T1 is ignored.
- Stop is sampled only on boundary edges and in HALT. Stop during T1–T6 does not shorten the instruction.
- Strobes change only after rising edges, except asynchronously at reset.
- Read and MDRin stay high for the whole of T1.

## Test plan
- Reset, then Clear high with MemDone tied 1 and IR=0x18918000 (add R1,R2,R3):
  - Required sequence: T0→T1→T2→T3 (Rout=0x0004, Yin) → T4 (Rout=0x0008, ALUop=00011, ZLowIn) → T5 (Zlowout, Rin=0x0002) → T0.
  - The loop is 6 cycles; Run=1 throughout.
- MemDone held low 3 extra cycles in T1: Read=MDRin=1 for exactly 4 cycles, the loop is 9 cycles, and there are no strobes outside T1 during the wait.
- IR=0x78118000 (mul R2,R3):
  - T4 asserts ZLowIn and ZHighIn with ALUop=01111.
  - T5 asserts Zlowout and LOin with Rin=0.
  - T6 asserts ZHighout and HIin. The loop is 7 cycles.
- IR=0xD8000000 (halt): after T3, HALT is entered with Run=0. Toggling Stop does not exit; only Clear low exits.
- Stop=1 raised in T4 of an add: R1 is still written in T5. Then HALT with Run=0; Stop=0 returns to T0 on the next edge.
- Clear pulsed low mid-T1: all outputs are 0 asynchronously, and after release the sequencer restarts at T0. Rin/Rout are checked as one-hot or zero every cycle.
